// File: rtl/bp_pkg.sv
// Shared types and counter arithmetic for the branch history table controller.
// Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Saturating step toward the resolved direction; never wraps.
    function automatic ctr_t sat_next(input ctr_t ctr, input logic taken);
        ctr_t result;
        result = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                result = ctr + 2'b01;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                result = ctr - 2'b01;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bht_controller.sv
// Branch history table of 2-bit saturating counters: post-reset init sweep,
// one lookup and one training update per cycle. Define BHT_GSHARE_EN for gshare indexing.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | sweep writes INIT_CTR to every entry; requests ignored
// RUN   | lookups and updates accepted; left only by reset
module bht_controller
    import bp_pkg::*;
#(
    parameter int   PC_W     = 32,
    parameter int   IDX_W    = 6,
    parameter ctr_t INIT_CTR = CTR_WNT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic            lookup_valid,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [1:0]      pred_ctr,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;

    ctr_t             tbl [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic             lk_acc;
    logic             up_acc;
    ctr_t             up_new;
    ctr_t             lk_ctr;

    // Only the word-index slice of each PC participates in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    assign ready  = (state == RUN);
    assign lk_acc = lookup_valid && ready;
    assign up_acc = upd_valid && ready;

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr <= '0;
        end else if (state == INIT) begin
            ghr <= '0;
        end else if (up_acc) begin
            ghr <= {ghr[IDX_W-2:0], upd_taken};
        end
    end

    // Both paths hash with the pre-shift history.
    assign lk_idx = lookup_pc[IDX_W+1:2] ^ ghr;
    assign up_idx = upd_pc[IDX_W+1:2] ^ ghr;
`else
    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign up_idx = upd_pc[IDX_W+1:2];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT: begin
                if (ptr == LAST_IDX) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // Table contents are undefined until the sweep completes, so no reset here.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            tbl[ptr] <= INIT_CTR;
        end else if (up_acc) begin
            tbl[up_idx] <= up_new;
        end
    end

    assign up_new = sat_next(tbl[up_idx], upd_taken);

    // Write-first bypass when lookup and update hit the same entry.
    always_comb begin
        lk_ctr = tbl[lk_idx];
        if (up_acc && (up_idx == lk_idx)) begin
            lk_ctr = up_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_ctr   <= CTR_SNT;
        end else begin
            pred_valid <= lk_acc;
            if (lk_acc) begin
                pred_ctr   <= lk_ctr;
                pred_taken <= lk_ctr[1];
            end
        end
    end

endmodule
